// File: rtl/aes_pkg.sv
// Shared AES constants and types: S-box, round constants, sequencer states.
package aes_pkg;

   localparam int unsigned WORD_W  = 32;
   localparam int unsigned STATE_W = 128;

   typedef enum logic [1:0] {NOKEY, READY, HOLD, STEP} state_e;

   // Forward S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Byte b sits at bit offset 8*(255-b), which is 8*~b.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[{~b, 3'b000} +: 8];
   endfunction

   // Round constant for rounds 1..10; round 0 never steps.
   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] c;
      case (r)
         4'd1:    c = 8'h01;
         4'd2:    c = 8'h02;
         4'd3:    c = 8'h04;
         4'd4:    c = 8'h08;
         4'd5:    c = 8'h10;
         4'd6:    c = 8'h20;
         4'd7:    c = 8'h40;
         4'd8:    c = 8'h80;
         4'd9:    c = 8'h1b;
         4'd10:   c = 8'h36;
         default: c = 8'h00;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/inv_key_step.sv
// One round of inverse AES-128 key expansion: round key rnd -> round key rnd-1.
module inv_key_step
   import aes_pkg::*;
(
   input  logic [STATE_W-1:0] key_in,
   input  logic [3:0]         rnd,
   output logic [STATE_W-1:0] key_out
);

   logic [WORD_W-1:0] k0, k1, k2, k3;
   logic [WORD_W-1:0] n3, rot, sub;

   assign k0  = key_in[127:96];
   assign k1  = key_in[95:64];
   assign k2  = key_in[63:32];
   assign k3  = key_in[31:0];

   // The recovered k3' feeds the SubWord(RotWord()) term for k0'.
   assign n3  = k3 ^ k2;
   assign rot = {n3[23:0], n3[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_sbox
      assign sub[8*i +: 8] = sbox(rot[8*i +: 8]);
   end

   assign key_out = {k0 ^ sub ^ {rcon(rnd), 24'h0}, k1 ^ k0, k2 ^ k1, n3};

endmodule

// File: rtl/inv_addroundkey_seq.sv
// Decryption AddRoundKey sequencer: applies round keys 10..0, regenerating each on the fly.
module inv_addroundkey_seq
   import aes_pkg::*;
#(
   parameter int unsigned NR = 10,
   parameter int unsigned SW = STATE_W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          key_load,
   input  logic [SW-1:0] last_key,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [SW-1:0] s_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [SW-1:0] m_data,
   output logic [3:0]    m_round,
   output logic          m_last,
   output logic          key_ok
);

   state_e        state_q, state_d;
   logic [SW-1:0] key_last_q, key_last_d;
   logic [SW-1:0] key_cur_q, key_cur_d;
   logic [3:0]    rnd_q, rnd_d;
   logic [SW-1:0] m_data_q, m_data_d;
   logic [3:0]    m_round_q, m_round_d;
   logic          m_last_q, m_last_d;
   logic [SW-1:0] key_prev;

   inv_key_step u_step (
      .key_in  (key_cur_q),
      .rnd     (rnd_q),
      .key_out (key_prev)
   );

   // Next-state logic; key_load overrides everything, including a same-cycle accept.
   always_comb begin
      state_d    = state_q;
      key_last_d = key_last_q;
      key_cur_d  = key_cur_q;
      rnd_d      = rnd_q;
      m_data_d   = m_data_q;
      m_round_d  = m_round_q;
      m_last_d   = m_last_q;
      case (state_q)
         NOKEY: ;
         READY: begin
            if (s_valid) begin
               m_data_d  = s_data ^ key_cur_q;
               m_round_d = rnd_q;
               m_last_d  = (rnd_q == 4'd0);
               state_d   = HOLD;
            end
         end
         HOLD: begin
            if (m_ready) begin
               if (rnd_q == 4'd0) begin
                  // Rewind so the next block starts again at round 10.
                  key_cur_d = key_last_q;
                  rnd_d     = 4'(NR);
                  state_d   = READY;
               end else begin
                  state_d = STEP;
               end
            end
         end
         STEP: begin
            key_cur_d = key_prev;
            rnd_d     = rnd_q - 4'd1;
            state_d   = READY;
         end
         default: state_d = NOKEY;
      endcase
      if (key_load) begin
         key_last_d = last_key;
         key_cur_d  = last_key;
         rnd_d      = 4'(NR);
         m_data_d   = m_data_q;
         m_round_d  = m_round_q;
         m_last_d   = m_last_q;
         state_d    = READY;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= NOKEY;
         key_last_q <= '0;
         key_cur_q  <= '0;
         rnd_q      <= 4'(NR);
         m_data_q   <= '0;
         m_round_q  <= 4'd0;
         m_last_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         key_last_q <= key_last_d;
         key_cur_q  <= key_cur_d;
         rnd_q      <= rnd_d;
         m_data_q   <= m_data_d;
         m_round_q  <= m_round_d;
         m_last_q   <= m_last_d;
      end
   end

   // Handshake flags come straight from the state, never from m_ready.
   always_comb begin
      s_ready = (state_q == READY);
      m_valid = (state_q == HOLD);
      key_ok  = (state_q != NOKEY);
      m_data  = m_data_q;
      m_round = m_round_q;
      m_last  = m_last_q;
   end

endmodule

// File: tb/tb_inv_addroundkey_seq.sv
// Self-checking bench: reference round keys derived from a word-level key schedule
// with an S-box built from GF(2^8) arithmetic.
module tb_inv_addroundkey_seq;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         key_load;
   logic [127:0] last_key;
   logic         s_valid;
   logic         s_ready;
   logic [127:0] s_data;
   logic         m_valid;
   logic         m_ready;
   logic [127:0] m_data;
   logic [3:0]   m_round;
   logic         m_last;
   logic         key_ok;

   inv_addroundkey_seq dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_load (key_load),
      .last_key (last_key),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_data   (s_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .m_round  (m_round),
      .m_last   (m_last),
      .key_ok   (key_ok)
   );

   always #5 clk = ~clk;

   int           vectors = 0;
   int           errors  = 0;
   logic [7:0]   sb [256];
   logic [7:0]   rc [1:10];
   logic [127:0] rk [0:10];
   int           mrnd;
   bit           pending = 0;
   bit           loaded  = 0;
   logic [127:0] exp_data;
   int           exp_round;
   time          t_acc, t_prev;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   task automatic build_tables();
      for (int a = 0; a < 256; a++) begin
         logic [7:0] inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
      rc[1] = 8'h01;
      for (int j = 2; j <= 10; j++) rc[j] = xtime(rc[j-1]);
   endtask

   // Run the forward schedule relation w[i+4] = w[i] ^ t(w[i+3]) backwards over 44 words.
   task automatic gen_keys(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      for (int j = 0; j < 4; j++) w[40+j] = k[127-32*j -: 32];
      for (int i = 39; i >= 0; i--) begin
         t = w[i+3];
         if ((i + 4) % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc[(i+4)/4], 24'h0};
         end
         w[i] = w[i+4] ^ t;
      end
      for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // Per-cycle check of the output interface against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("key_ok", 128'(key_ok), 128'(loaded));
         chk("m_valid", 128'(m_valid), 128'(pending));
         if (pending) begin
            chk("m_data", m_data, exp_data);
            chk("m_round", 128'(m_round), 128'(exp_round));
            chk("m_last", 128'(m_last), 128'(exp_round == 0));
         end
         if (m_valid) chk("s_ready_while_valid", 128'(s_ready), 128'd0);
      end
   end

   task automatic load(input logic [127:0] k);
      key_load = 1'b1;
      last_key = k;
      @(posedge clk);
      #1 key_load = 1'b0;
      pending = 0;
      loaded  = 1;
      mrnd    = 10;
      gen_keys(k);
   endtask

   task automatic accept(input logic [127:0] d, input bit mr);
      bit ok = 0;
      s_valid = 1'b1;
      s_data  = d;
      m_ready = mr;
      for (int i = 0; i < 20; i++) begin
         if (s_ready) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) $display("FAIL accept_timeout: s_ready got 0 expected 1 at %0t", $time);
      if (!ok) errors++;
      @(posedge clk);
      #1 s_valid = 1'b0;
      t_prev    = t_acc;
      t_acc     = $time;
      exp_data  = d ^ rk[mrnd];
      exp_round = mrnd;
      pending   = 1;
   endtask

   task automatic finish_out(input int delay);
      bit was_last;
      if (delay > 0) begin
         m_ready = 1'b0;
         repeat (delay) @(posedge clk);
         #1 m_ready = 1'b1;
      end
      @(posedge clk);
      #1 m_ready = 1'b0;
      pending  = 0;
      was_last = (mrnd == 0);
      mrnd     = was_last ? 10 : mrnd - 1;
      @(negedge clk);
      chk("s_ready_after_out", 128'(s_ready), 128'(was_last));
      if (!was_last) begin
         @(negedge clk);
         chk("s_ready_after_step", 128'(s_ready), 128'd1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      key_load = 1'b0;
      last_key = '0;
      s_valid  = 1'b0;
      s_data   = '0;
      m_ready  = 1'b0;
      t_acc    = 0;
      build_tables();
      gen_keys(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      chk("model_rk10", rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      chk("model_rk9", rk[9], 128'hac7766f319fadc2128d12941575c006e);
      chk("model_rk0", rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

      #1;
      chk("rst_m_valid", 128'(m_valid), 128'd0);
      chk("rst_s_ready", 128'(s_ready), 128'd0);
      chk("rst_key_ok", 128'(key_ok), 128'd0);
      chk("rst_m_data", m_data, 128'd0);
      chk("rst_m_round_last", 128'({m_round, m_last}), 128'd0);
      #12 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Known-answer vector at round 10, output one cycle after acceptance.
      load(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      accept(128'h3925841d02dc09fbdc118597196a0b32, 1'b1);
      chk("kat_round10", m_data, 128'he9317db5cb322c723d2e895faf090794);
      chk("kat_round10_idx", 128'(m_round), 128'd10);
      finish_out(0);

      // Stall at round 9, then all remaining rounds back-to-back with m_ready preset.
      accept(128'h0, 1'b0);
      chk("lit_round9", m_data, 128'hac7766f319fadc2128d12941575c006e);
      finish_out(5);
      for (int r = 8; r >= 0; r--) begin
         accept(128'h0, 1'b1);
         if (r < 8) chk("throughput", 128'(t_acc - t_prev), 128'd30);
         if (r == 0) begin
            chk("lit_round0", m_data, 128'h2b7e151628aed2a6abf7158809cf4f3c);
            chk("lit_last", 128'(m_last), 128'd1);
         end
         finish_out(0);
      end
      // Automatic rewind to round 10.
      accept(128'h0, 1'b1);
      chk("rewind_data", m_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      chk("rewind_round", 128'(m_round), 128'd10);
      finish_out(0);

      // key_load while holding round 6 aborts and restarts at round 10.
      for (int r = 9; r >= 7; r--) begin
         accept(128'h0, 1'b1);
         finish_out(0);
      end
      accept(128'h0, 1'b0);
      chk("hold_round6", 128'(m_round), 128'd6);
      @(posedge clk);
      #1;
      load({128{1'b1}});
      @(negedge clk);
      chk("abort_s_ready", 128'(s_ready), 128'd1);
      accept(128'h0, 1'b1);
      chk("abort_data", m_data, {128{1'b1}});
      chk("abort_round", 128'(m_round), 128'd10);
      finish_out(0);

      // key_load with a simultaneous s_valid: the state is not accepted.
      s_valid = 1'b1;
      s_data  = 128'h1234;
      load(128'h000102030405060708090a0b0c0d0e0f);
      s_valid = 1'b0;
      @(negedge clk);
      chk("load_beats_valid", 128'(s_ready), 128'd1);

      // Randomised blocks with random keys, data and back-pressure.
      for (int b = 0; b < 6; b++) begin
         int n = $urandom_range(23, 11);
         load({$urandom, $urandom, $urandom, $urandom});
         for (int i = 0; i < n; i++) begin
            bit mr = 1'($urandom_range(1, 0));
            accept({$urandom, $urandom, $urandom, $urandom}, mr);
            finish_out(mr ? 0 : int'($urandom_range(3, 1)));
         end
      end

      // Reset asserted during STEP clears everything asynchronously.
      load(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      accept(128'h5a5a, 1'b1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      pending = 0;
      loaded  = 0;
      #1;
      chk("mid_rst_m_valid", 128'(m_valid), 128'd0);
      chk("mid_rst_outputs", {m_data ^ 128'(m_round) ^ 128'(m_last)}, 128'd0);
      chk("mid_rst_m_round", 128'({m_round, m_last, key_ok, s_ready}), 128'd0);
      #5 rst_n = 1'b1;
      s_valid = 1'b1;
      s_data  = 128'hff;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("post_rst_s_ready", 128'(s_ready), 128'd0);
      end
      s_valid = 1'b0;
      @(posedge clk);
      #1;
      load(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      accept(128'h0, 1'b1);
      chk("post_rst_round10", m_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      finish_out(0);

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
